// File: rtl/imdct_seq_pkg.sv
// imdct_seq_pkg
// Shared definitions for the IMDCT frame sequencer.
//   state_t     : sequencer FSM states
//   FRAME_LONG  : words per frame when tabidx = 1
//   FRAME_SHORT : words per frame when tabidx = 0
//   ADDR_W      : engine RAM address width
//   SKID_W      : skid entry width (32-bit data + last flag)
package imdct_seq_pkg;

  localparam int unsigned FRAME_LONG  = 1024;
  localparam int unsigned FRAME_SHORT = 128;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned SKID_W      = 33;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_FILL  = 3'd2,
    ST_KICK  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_DRAIN = 3'd5
  } state_t;

endpackage

// File: rtl/imdct_seq_skid.sv
// imdct_seq_skid
// Two-entry FIFO holding engine read data ({last, data}) on its way to the
// output stream. Occupancy is exported so the sequencer can throttle reads.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   i_push     : write i_data (caller guarantees the buffer is not full)
//   i_data     : {last, data} entry
//   i_pop      : consumer ready; an entry leaves when o_valid & i_pop
//   o_valid    : buffer non-empty
//   o_data     : head entry
//   o_occ      : number of stored entries (0..2)
module imdct_seq_skid
  import imdct_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [SKID_W-1:0] i_data,
  input  logic              i_pop,
  output logic              o_valid,
  output logic [SKID_W-1:0] o_data,
  output logic [1:0]        o_occ
);

  logic [SKID_W-1:0] r_mem [2];
  logic              r_wr_ptr;
  logic              r_rd_ptr;
  logic [1:0]        r_occ;
  logic              w_pop;

  assign w_pop   = i_pop && (r_occ != 2'd0);
  assign o_valid = (r_occ != 2'd0);
  assign o_data  = r_mem[r_rd_ptr];
  assign o_occ   = r_occ;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_occ    <= 2'd0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      // Push and pop together leave the occupancy unchanged.
      case ({i_push, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule

// File: rtl/imdct_frame_sequencer.sv
// imdct_frame_sequencer
// Frame controller for the dual-function IMDCT/FFT RAM engine: loads one
// frame of coefficients into the engine RAM, pulses start, waits for done,
// then streams the processed frame out.
// Optional feature macro: IMDCT_SEQ_WATCHDOG_EN (WAIT timeout of TIMEOUT
// cycles; on expiry frame_err is set and the frame is abandoned).
// Ports:
//   clk, rst_n            : clock, synchronous active-low reset
//   cfg_*                 : frame configuration, latched on IDLE->LOAD
//   s_valid/s_ready/s_data/s_last : input coefficient stream
//   m_valid/m_ready/m_data/m_last : output sample stream
//   busy                  : state is not IDLE
//   frame_err             : sticky frame error, cleared when a frame starts
//   eng_*                 : engine RAM port, start/done and controls
// Both streams use valid/ready: a word transfers on a clock edge where
// valid and ready are both high; valid never depends on ready.
module imdct_frame_sequencer
  import imdct_seq_pkg::*;
#(
  parameter int unsigned TIMEOUT = 65535
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_tabidx,
  input  logic              cfg_mode,
  input  logic              cfg_func,
  input  logic              cfg_auto,
  input  logic [4:0]        cfg_es,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [31:0]       s_data,
  input  logic              s_last,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [31:0]       m_data,
  output logic              m_last,
  output logic              busy,
  output logic              frame_err,
  output logic [31:0]       eng_din,
  output logic              eng_we,
  output logic              eng_ram_en,
  output logic [ADDR_W-1:0] eng_addr,
  output logic              eng_start,
  output logic              eng_tabidx,
  output logic              eng_mode,
  output logic              eng_func,
  output logic              eng_auto,
  output logic              eng_bit_rev,
  output logic [4:0]        eng_es,
  input  logic [31:0]       eng_dout,
  input  logic              eng_done,
  input  logic              eng_progress
);

  state_t            r_state;
  logic [ADDR_W-1:0] r_cnt;
  logic [ADDR_W-1:0] r_rcnt;
  logic              r_tabidx;
  logic              r_mode;
  logic              r_func;
  logic              r_auto;
  logic [4:0]        r_es;
  logic              r_frame_err;
  logic              r_rd_all;
  logic              r_inflight;
  logic              r_inflight_last;

  logic [ADDR_W-1:0] w_last_addr;
  logic              w_load_hs;
  logic              w_rd_issue;
  logic              w_pop;
  logic              w_skid_valid;
  logic [SKID_W-1:0] w_skid_data;
  logic [1:0]        w_occ;
  logic [1:0]        w_occ_net;

`ifdef IMDCT_SEQ_WATCHDOG_EN
  logic [15:0]       r_wd;
`else
  logic              w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
`endif

  assign w_last_addr = r_tabidx ? ADDR_W'(FRAME_LONG - 1) : ADDR_W'(FRAME_SHORT - 1);
  assign s_ready     = (r_state == ST_LOAD);
  assign w_load_hs   = s_ready && s_valid;
  assign w_pop       = w_skid_valid && m_ready;

  // Occupancy net of this cycle's pop, so a steady m_ready sustains one
  // read per cycle while the buffer plus the read in flight never exceed 2.
  assign w_occ_net  = w_occ - {1'b0, w_pop};
  assign w_rd_issue = (r_state == ST_DRAIN) && !r_rd_all &&
                      (({1'b0, w_occ_net} + {2'b00, r_inflight}) < 3'd2);

  // Engine RAM port: load writes, zero-fill writes and drain reads never
  // overlap because they belong to different states.
  always_comb begin
    eng_we     = 1'b0;
    eng_ram_en = 1'b0;
    eng_addr   = '0;
    eng_din    = '0;
    if (w_load_hs) begin
      eng_we     = 1'b1;
      eng_ram_en = 1'b1;
      eng_addr   = r_cnt;
      eng_din    = s_data;
    end else if (r_state == ST_FILL) begin
      eng_we     = 1'b1;
      eng_ram_en = 1'b1;
      eng_addr   = r_cnt;
    end else if (w_rd_issue) begin
      eng_ram_en = 1'b1;
      eng_addr   = r_rcnt;
    end
  end

  assign eng_start   = (r_state == ST_KICK);
  assign eng_tabidx  = r_tabidx;
  assign eng_mode    = r_mode;
  assign eng_func    = r_func;
  assign eng_auto    = r_auto;
  assign eng_es      = r_es;
  assign eng_bit_rev = 1'b0;
  assign busy        = (r_state != ST_IDLE);
  assign frame_err   = r_frame_err;
  assign m_valid     = w_skid_valid;
  assign m_data      = w_skid_data[31:0];
  assign m_last      = w_skid_data[32];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state         <= ST_IDLE;
      r_cnt           <= '0;
      r_rcnt          <= '0;
      r_tabidx        <= 1'b0;
      r_mode          <= 1'b0;
      r_func          <= 1'b0;
      r_auto          <= 1'b0;
      r_es            <= '0;
      r_frame_err     <= 1'b0;
      r_rd_all        <= 1'b0;
      r_inflight      <= 1'b0;
      r_inflight_last <= 1'b0;
`ifdef IMDCT_SEQ_WATCHDOG_EN
      r_wd            <= '0;
`endif
    end else begin
      // Read data returns one cycle after issue; tag the final address.
      r_inflight      <= w_rd_issue;
      r_inflight_last <= w_rd_issue && (r_rcnt == w_last_addr);

      case (r_state)
        ST_IDLE: begin
          if (s_valid && !eng_progress) begin
            r_tabidx    <= cfg_tabidx;
            r_mode      <= cfg_mode;
            r_func      <= cfg_func;
            r_auto      <= cfg_auto;
            r_es        <= cfg_es;
            r_frame_err <= 1'b0;
            r_cnt       <= '0;
            r_state     <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (w_load_hs) begin
            if (r_cnt == w_last_addr) begin
              if (!s_last) r_frame_err <= 1'b1;
              r_state <= ST_KICK;
            end else begin
              r_cnt <= r_cnt + 1'b1;
              if (s_last) begin
                r_frame_err <= 1'b1;
                r_state     <= ST_FILL;
              end
            end
          end
        end
        ST_FILL: begin
          if (r_cnt == w_last_addr) r_state <= ST_KICK;
          else                      r_cnt   <= r_cnt + 1'b1;
        end
        ST_KICK: begin
          r_state <= ST_WAIT;
`ifdef IMDCT_SEQ_WATCHDOG_EN
          r_wd    <= '0;
`endif
        end
        ST_WAIT: begin
          // Every engine completion (IMDCT, chained or single FFT) ends WAIT.
          if (eng_done) begin
            r_rcnt   <= '0;
            r_rd_all <= 1'b0;
            r_state  <= ST_DRAIN;
          end
`ifdef IMDCT_SEQ_WATCHDOG_EN
          else if (r_wd == 16'(TIMEOUT - 1)) begin
            r_frame_err <= 1'b1;
            r_state     <= ST_IDLE;
          end else begin
            r_wd <= r_wd + 16'd1;
          end
`endif
        end
        ST_DRAIN: begin
          if (w_rd_issue) begin
            if (r_rcnt == w_last_addr) r_rd_all <= 1'b1;
            else                       r_rcnt   <= r_rcnt + 1'b1;
          end
          if (w_pop && w_skid_data[32]) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  imdct_seq_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (r_inflight),
    .i_data  ({r_inflight_last, eng_dout}),
    .i_pop   (m_ready),
    .o_valid (w_skid_valid),
    .o_data  (w_skid_data),
    .o_occ   (w_occ)
  );

endmodule
